// File: rtl/key_capture_pkg.sv
// key_capture_pkg: shared constants for the key capture peripheral.
//   - Avalon word offsets of the four registers
//   - default debounce length (10 ms at 50 MHz)
//   - helper that sizes the debounce counter
package key_capture_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned PRESS_COUNT_W           = 16;

  // Counter only has to reach DEBOUNCE_CYCLES-1.
  function automatic int unsigned debounce_cnt_w(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_capture_avalon_debounce.sv
// key_debounce: two-flop synchroniser plus debounce counter for one key.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   raw_in      - asynchronous raw key level (1 = pressed)
//   stable      - debounced level
//   rise, fall  - single-cycle strobes, high in the cycle before the edge on
//                 which stable changes to 1 / 0 respectively
module key_debounce
  import key_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned          CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        accept   = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    stable = stable_q;
    // Strobes are combinational so the capture logic updates on the same
    // edge as the stable level.
    rise   = accept & sync2_q;
    fall   = accept & ~sync2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/key_capture_avalon.sv
// key_capture_avalon: Avalon-MM slave carrying debounced pushbuttons to the HPS.
// Registers: 0 DATA (RO), 1 IRQ_MASK (RW), 2 EDGE_CAPTURE (W1C), 3 PRESS_COUNT
// (RO, any write clears). Read latency 1, no waitrequest.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   keys_in[WIDTH-1:0]    - raw pressed levels, asynchronous
//   avs_address/read/write/writedata/readdata - Avalon-MM slave
//   irq                   - level interrupt, |(EDGE_CAPTURE & IRQ_MASK)
// Build option: define KEY_CAPTURE_RELEASE_EN to also capture release events
// in EDGE_CAPTURE[2*WIDTH-1:WIDTH] (IRQ_MASK widens to match).
module key_capture_avalon
  import key_capture_pkg::*;
#(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

`ifdef KEY_CAPTURE_RELEASE_EN
  localparam int unsigned CAP_W = 2 * WIDTH;
`else
  localparam int unsigned CAP_W = WIDTH;
`endif

  logic [WIDTH-1:0]         stable, rise, fall;
  logic [CAP_W-1:0]         events;
  logic [PRESS_COUNT_W-1:0] press_cnt;

  logic [CAP_W-1:0]         mask_q, mask_d;
  logic [CAP_W-1:0]         edge_q, edge_d;
  logic [PRESS_COUNT_W-1:0] count_q, count_d;
  logic [31:0]              readdata_q, readdata_d;
  logic                     unused_ok;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw_in (keys_in[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  always_comb begin
`ifdef KEY_CAPTURE_RELEASE_EN
    events    = {fall, rise};
    unused_ok = ^avs_writedata;
`else
    events    = rise;
    unused_ok = ^{fall, avs_writedata};
`endif
  end

  always_comb begin
    press_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      press_cnt = press_cnt + PRESS_COUNT_W'(rise[i]);
    end
  end

  always_comb begin
    mask_d  = mask_q;
    edge_d  = edge_q;
    count_d = count_q;
    if (avs_write && avs_address == ADDR_MASK) begin
      mask_d = avs_writedata[CAP_W-1:0];
    end
    if (avs_write && avs_address == ADDR_EDGE) begin
      edge_d = edge_q & ~avs_writedata[CAP_W-1:0];
    end
    if (avs_write && avs_address == ADDR_COUNT) begin
      count_d = '0;
    end
    // New events are applied after the clear so a colliding press wins.
    edge_d  = edge_d | events;
    count_d = count_d + press_cnt;
  end

  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      readdata_d = '0;
      case (avs_address)
        ADDR_DATA:  readdata_d[WIDTH-1:0]         = stable;
        ADDR_MASK:  readdata_d[CAP_W-1:0]         = mask_q;
        ADDR_EDGE:  readdata_d[CAP_W-1:0]         = edge_q;
        ADDR_COUNT: readdata_d[PRESS_COUNT_W-1:0] = count_q;
        default:    readdata_d                    = '0;
      endcase
    end
  end

  always_comb begin
    avs_readdata = readdata_q;
    irq          = |(edge_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= '0;
      edge_q     <= '0;
      count_q    <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: doc/key_capture_avalon.md
# key_capture_avalon

Avalon-MM slave peripheral that carries the pushbutton inputs from the FPGA fabric to the HPS, complementing the HPS-to-FPGA readback path that drives the hex displays and LEDs. Each key goes through a synchroniser and debouncer. Press edges are latched into a write-1-to-clear capture register and counted in a press counter, and a level interrupt is raised towards the HPS. The block instantiates inside the Qsys system on the 50 MHz system reference clock. The top level feeds it the active-high pressed levels (~KEY[3:1]).

## Interface
Parameters:
- WIDTH, 3: number of key inputs (1..16).
- DEBOUNCE_CYCLES, 500000: consecutive disagreeing clocks required to accept a new level (10 ms at 50 MHz); minimum 2.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- keys_in  in  WIDTH  raw key levels, 1 = pressed, asynchronous to clk.
- avs_address  in  2  word address of the register.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  level interrupt, active-high.

## Operation
Register map (word offsets):
- 0 DATA: RO; bits [WIDTH-1:0] hold the debounced levels; writes are ignored.
- 1 IRQ_MASK: RW; bits [WIDTH-1:0]; upper bits read 0.
- 2 EDGE_CAPTURE: read returns the capture bits. A write clears every bit whose writedata bit is 1.
- 3 PRESS_COUNT: RO bits [15:0]; any write clears it to 0.

Synchroniser and debounce, per bit:
- Each bit passes through a two-flop synchroniser into a debounce counter.
- The counter increments while the synchronised value differs from the stable value.
- The counter resets to 0 whenever the synchronised value equals the stable value.
- When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, stable takes the synchronised value and the counter returns to 0.

Edge capture and counting:
- A 0→1 transition of the stable value is a press event.
- A press event sets its EDGE_CAPTURE bit.
- PRESS_COUNT adds the number of press events that occur in the cycle (popcount). It is 16 bits wide and wraps from 0xFFFF to 0x0000.
- irq = |(EDGE_CAPTURE & IRQ_MASK).

Simultaneous events:
- A W1C write and a new press on the same bit in the same cycle: the bit ends set, because the press wins.
- A PRESS_COUNT clear in the same cycle as press events: the count becomes the popcount of that cycle.
- A read and a write in the same cycle are not legal. If they occur, the write takes effect and readdata returns the pre-write value.

Reset:
- Clears all synchronisers, stable values, counters, IRQ_MASK, EDGE_CAPTURE and PRESS_COUNT.
- Drives avs_readdata = 0 and irq = 0.
- Reset asserted mid-debounce discards the partial count.
- A key held through the release of reset produces a press event DEBOUNCE_CYCLES+2 edges after reset deasserts.

## Timing
- Read latency is fixed at 1 clock and there is no waitrequest. avs_readdata is valid on the clock after avs_read and holds until the next read.
- Writes take effect on the edge where avs_write is sampled high.
- A constant raw change first sampled on edge k updates the stable value on edge k+DEBOUNCE_CYCLES+1. EDGE_CAPTURE and PRESS_COUNT update on that same edge.
- irq rises in the same cycle as the capture bit, with no extra register stage.
- An input glitch shorter than DEBOUNCE_CYCLES synchronised clocks causes no change.

## Configuration
- KEY_CAPTURE_RELEASE_EN defined:
  - Release events (1→0 of the stable value) are also captured, in EDGE_CAPTURE bits [2*WIDTH-1:WIDTH].
  - IRQ_MASK widens to match, and irq covers both halves.
  - W1C behaves identically on both halves.
  - PRESS_COUNT still counts presses only.
- KEY_CAPTURE_RELEASE_EN undefined:
  - Bits [31:WIDTH] of EDGE_CAPTURE and IRQ_MASK read 0 and ignore writes.

## Structure
- Package key_capture_pkg holds:
  - register offset localparams ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_COUNT=3;
  - default DEBOUNCE_CYCLES;
  - counter width derived by $clog2.
- Sub-module key_debounce: one instance per bit, containing the synchroniser and counter. It outputs the stable level plus single-cycle rise and fall strobes.
- The top of the block holds the register file, the popcount adder and the read mux.

## Test plan
Run with WIDTH=3 and DEBOUNCE_CYCLES=4.
- Reset values: assert reset for 3 cycles, then read all four offsets → readdata 0 each; irq=0.
- Press with interrupt enabled:
  - Write IRQ_MASK=0x7, then hold keys_in=3'b001.
  - On edge k+5, DATA=0x1, EDGE_CAPTURE=0x1, PRESS_COUNT=1 and irq=1.
  - Write EDGE_CAPTURE=0x1 → irq=0 on the following cycle.
- Glitch rejection: pulse keys_in[1] high for 3 cycles → DATA, EDGE_CAPTURE and PRESS_COUNT remain 0.
- Simultaneous presses:
  - keys_in 3'b000→3'b110 together → PRESS_COUNT=2, EDGE_CAPTURE=0x6.
  - With IRQ_MASK=0x2, irq=1.
  - Write 0x2 to EDGE_CAPTURE → EDGE_CAPTURE=0x4 and irq=0.
- Clear/press collision:
  - Issue a W1C of bit 0 on the exact edge where key 0's press is accepted → bit 0 stays 1.
  - Write PRESS_COUNT on that same edge → count=1.
- Wrap and mid-operation reset:
  - Force PRESS_COUNT to 0xFFFF via 65535 presses (or a backdoor), then one press → 0x0000.
  - Assert reset 2 cycles into a debounce → no event.
  - Key still held after reset releases → press accepted 6 edges later.
